pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before core reset release.
REQ-002 Parameter LOCK_TIMEOUT_CYCLES, default 742500 (10 ms at 74.25 MHz): WAIT_LOCK cycles before the PLL is re-reset.
REQ-003 Parameter PLL_RST_CYCLES, default 16: width of the pll_rst pulse, in clocks.
REQ-004 Parameter SYNC_STAGES, default 2, minimum 2: flip-flop depth of the pll_locked synchronizer.
REQ-005 Port clk_74a, input, 1: free-running 74.25 MHz reference clock; the single clock of the block.
REQ-006 Port reset_n, input, 1: asynchronous active-low reset.
REQ-007 Port pll_locked, input, 1: PLL locked output; asynchronous to clk_74a.
REQ-008 Port pll_rst, output, 1: active-high reset to the PLL rst input.
REQ-009 Port core_reset_n, output, 1: active-low reset for the 96/48/6 MHz core domains.
REQ-010 Port ready, output, 1: high only in RUN.
REQ-011 Port relock_count, output, 8: number of lock losses seen in RUN; saturates at 255.
REQ-012 Port timeout_err, output, 1: sticky flag set when a lock timeout occurs.
REQ-013 Port clear_err, input, 1: synchronous pulse that clears timeout_err and relock_count.

Function
REQ-014 pll_locked SHALL pass through a SYNC_STAGES flip-flop chain to form lock_s; no other logic SHALL use pll_locked directly.
REQ-015 The FSM SHALL have four states: PLL_RST, WAIT_LOCK, STABLE and RUN; all outputs SHALL be registered.
REQ-016 PLL_RST: pll_rst=1 and core_reset_n=0; after PLL_RST_CYCLES clocks the FSM SHALL go to WAIT_LOCK; lock_s SHALL be ignored in this state.
REQ-017 WAIT_LOCK: pll_rst=0 and the timeout counter increments each cycle; when lock_s=1 the FSM SHALL go to STABLE and clear the counter.
REQ-018 WAIT_LOCK: when the timeout counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0, the FSM SHALL go to PLL_RST and set timeout_err.
REQ-019 STABLE: the stable counter increments each cycle lock_s=1; any lock_s=0 SHALL return the FSM to WAIT_LOCK with both counters cleared.
REQ-020 STABLE lasts exactly LOCK_STABLE_CYCLES cycles when lock is clean; it then goes to RUN with core_reset_n=1 and ready=1 in the same cycle.
REQ-021 core_reset_n SHALL rise on the (SYNC_STAGES+LOCK_STABLE_CYCLES+1)th rising edge after the first edge that samples pll_locked high.
REQ-022 RUN: lock_s=0 SHALL, on the next edge, drive core_reset_n=0 and ready=0, increment relock_count (saturating at 255) and enter WAIT_LOCK with no pll_rst pulse.
REQ-023 If clear_err and a timeout or relock increment occur in the same cycle, the set or increment SHALL win.
REQ-024 The counter widths SHALL be $clog2 of their parameter; the counters SHALL hold no value beyond the terminal count.

Reset
REQ-025 On reset_n=0 (asynchronous), the block SHALL set state=PLL_RST, pll_rst=1, core_reset_n=0, ready=0, relock_count=0, timeout_err=0, all counters and synchronizer flops to 0.
REQ-026 Deassertion of reset_n SHALL take effect synchronously; the PLL_RST pulse length then counts from the first edge after deassertion.
REQ-027 Assertion of reset_n in any state, including mid-STABLE, SHALL restart the full sequence.

Structure
REQ-028 Package pll_seq_pkg SHALL hold the state enum, the default parameter constants and the counter-width functions.
REQ-029 A single sub-module, sync_bit, SHALL implement the parameterized synchronizer and carry the synchronizer timing attributes.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset release, then pll_locked=1 at cycle 40 -> pll_rst high for cycles 1-16; core_reset_n rises at edge 40+2+1024+1; ready=1.
- pll_locked never rises -> timeout_err=1 after 16+742500 cycles; a second 16-cycle pll_rst pulse follows.
- pll_locked drops for 1 cycle midway through STABLE -> return to WAIT_LOCK; core_reset_n stays 0; stable count restarts; relock_count stays 0.
- In RUN, 300 lock-loss events -> relock_count=255 (saturated); each loss drops core_reset_n within SYNC_STAGES+1 edges; no pll_rst pulse.
- clear_err on the same cycle as a timeout -> timeout_err=1; clear_err alone on a later cycle -> timeout_err=0 and relock_count=0.
- reset_n asserted mid-RUN -> outputs take their reset values without waiting for a clock edge; the sequence restarts from PLL_RST.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared state encoding, default timing constants and counter sizing for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } pll_seq_state_e;

  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 742500;  // 10 ms at 74.25 MHz
  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_SYNC_STAGES         = 2;

  // A counter that runs 0..n-1 needs $clog2(n) bits; keep at least one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Multi-flop synchronizer bringing one asynchronous level into the local clock domain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, waits for a clean lock, then releases the core reset; re-enters on lock loss.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input  logic           clk_74a,
  input  logic           reset_n,
  input  logic           pll_locked,
  input  logic           clear_err,
  output logic           pll_rst,
  output logic           core_reset_n,
  output logic           ready,
  output logic [7:0]     relock_count,
  output logic           timeout_err,
  output pll_seq_state_e o_dbg_state
);

  localparam int RST_W = cnt_w(PLL_RST_CYCLES);
  localparam int TO_W  = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int ST_W  = cnt_w(LOCK_STABLE_CYCLES);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(LOCK_STABLE_CYCLES - 1);

  logic w_lock_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk  (clk_74a),
    .i_rst_n(reset_n),
    .i_d    (pll_locked),
    .o_q    (w_lock_s)
  );

  pll_seq_state_e   r_state, w_state_nxt;
  logic [RST_W-1:0] r_rst_cnt, w_rst_cnt_nxt;
  logic [TO_W-1:0]  r_to_cnt, w_to_cnt_nxt;
  logic [ST_W-1:0]  r_st_cnt, w_st_cnt_nxt;
  logic             w_timeout_hit;
  logic             w_relock_hit;

  logic             r_pll_rst;
  logic             r_core_reset_n;
  logic             r_ready;
  logic [7:0]       r_relock_count;
  logic             r_timeout_err;

  // Every counter defaults to zero, so leaving a state always clears its counter.
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = '0;
    w_to_cnt_nxt  = '0;
    w_st_cnt_nxt  = '0;
    w_timeout_hit = 1'b0;
    w_relock_hit  = 1'b0;
    case (r_state)
      ST_PLL_RST: begin
        if (r_rst_cnt == RST_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = ST_STABLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt   = ST_PLL_RST;
          w_timeout_hit = 1'b1;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
      end
      ST_STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_st_cnt == ST_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_st_cnt_nxt = r_st_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt  = ST_WAIT_LOCK;
          w_relock_hit = 1'b1;
        end
      end
      default: w_state_nxt = ST_PLL_RST;
    endcase
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_PLL_RST;
      r_rst_cnt <= '0;
      r_to_cnt  <= '0;
      r_st_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_cnt <= w_rst_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_st_cnt  <= w_st_cnt_nxt;
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_pll_rst      <= 1'b1;
      r_core_reset_n <= 1'b0;
      r_ready        <= 1'b0;
      r_relock_count <= 8'd0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_pll_rst      <= (w_state_nxt == ST_PLL_RST);
      r_core_reset_n <= (w_state_nxt == ST_RUN);
      r_ready        <= (w_state_nxt == ST_RUN);
      if (w_timeout_hit) begin
        r_timeout_err <= 1'b1;
      end else if (clear_err) begin
        r_timeout_err <= 1'b0;
      end
      // A relock event beats a simultaneous clear.
      if (w_relock_hit) begin
        if (r_relock_count != 8'hFF) begin
          r_relock_count <= r_relock_count + 8'd1;
        end
      end else if (clear_err) begin
        r_relock_count <= 8'd0;
      end
    end
  end

  assign pll_rst      = r_pll_rst;
  assign core_reset_n = r_core_reset_n;
  assign ready        = r_ready;
  assign relock_count = r_relock_count;
  assign timeout_err  = r_timeout_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with shortened timing parameters and a queued scoreboard.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  localparam int ST   = 64;
  localparam int TO   = 200;
  localparam int RST  = 16;
  localparam int SYNC = 2;

  logic           clk_74a = 1'b0;
  logic           reset_n;
  logic           pll_locked;
  logic           clear_err;
  logic           pll_rst;
  logic           core_reset_n;
  logic           ready;
  logic [7:0]     relock_count;
  logic           timeout_err;
  pll_seq_state_e dbg_state;

  int checks;
  int failures;
  int edge_n;
  logic [7:0] exp_relock;

  logic [13:0] exp_q[$];
  string       tag_q[$];

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES (ST),
    .LOCK_TIMEOUT_CYCLES(TO),
    .PLL_RST_CYCLES     (RST),
    .SYNC_STAGES        (SYNC)
  ) dut (
    .clk_74a     (clk_74a),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .clear_err   (clear_err),
    .pll_rst     (pll_rst),
    .core_reset_n(core_reset_n),
    .ready       (ready),
    .relock_count(relock_count),
    .timeout_err (timeout_err),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk_74a = ~clk_74a;

  task automatic tick();
    @(posedge clk_74a);
    edge_n++;
    #1;
  endtask

  task automatic tick_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic do_release();
    @(negedge clk_74a);
    reset_n = 1'b1;
    edge_n  = 0;
  endtask

  // expected output vector: {pll_rst, core_reset_n, ready, timeout_err, relock_count, state}
  function automatic logic [13:0] mk(input logic te, input logic [7:0] rc, input pll_seq_state_e st);
    logic pr;
    logic run;
    pr  = (st == ST_PLL_RST);
    run = (st == ST_RUN);
    return {pr, run, run, te, rc, 2'(st)};
  endfunction

  function automatic logic [13:0] obs();
    return {pll_rst, core_reset_n, ready, timeout_err, relock_count, 2'(dbg_state)};
  endfunction

  // scoreboard
  task automatic exp_push(input string tag, input logic [13:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic exp_check();
    logic [13:0] v;
    string       t;
    logic [13:0] o;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty obs=%h exp=none", obs());
    end else begin
      v = exp_q.pop_front();
      t = tag_q.pop_front();
      o = obs();
      assert (o === v) else begin
        failures++;
        $error("FAIL %s obs=%h exp=%h", t, o, v);
      end
    end
  endtask

  task automatic chk_now(input string tag, input logic [13:0] v);
    exp_push(tag, v);
    exp_check();
  endtask

  task automatic chk1(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s obs=%b exp=%b", tag, o, e);
    end
  endtask

  task automatic check_rst_pulse(input string tag);
    for (int e = 1; e <= RST; e++) begin
      tick();
      chk_now(tag, mk(1'b0, exp_relock, (e < RST) ? ST_PLL_RST : ST_WAIT_LOCK));
    end
  endtask

  // one-cycle lock drop while in RUN, optionally racing a clear_err with the increment
  task automatic lose_lock(input logic with_clear);
    int   t0;
    logic any_rst;
    t0 = edge_n;
    pll_locked = 1'b0;
    exp_relock = (exp_relock == 8'hFF) ? 8'hFF : exp_relock + 8'd1;
    exp_push("relock_drop", mk(1'b0, exp_relock, ST_WAIT_LOCK));
    tick();
    pll_locked = 1'b1;
    tick();
    chk1("relock_hold", core_reset_n, 1'b1);
    if (with_clear) clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    exp_check();
    any_rst = 1'b0;
    while (edge_n < t0 + 3 + ST) begin
      tick();
      any_rst = any_rst | pll_rst;
    end
    chk1("relock_no_pll_rst", any_rst, 1'b0);
    tick();
    chk_now("relock_run", mk(1'b0, exp_relock, ST_RUN));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    edge_n     = 0;
    exp_relock = 8'd0;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    clear_err  = 1'b0;

    // reset values, then a clean lock at edge 40
    repeat (2) tick();
    chk_now("reset_values", mk(1'b0, 8'd0, ST_PLL_RST));
    do_release();
    check_rst_pulse("rst_pulse");
    tick_to(40);
    pll_locked = 1'b1;
    tick_to(40 + SYNC);
    chk_now("sync_latency", mk(1'b0, 8'd0, ST_WAIT_LOCK));
    tick();
    chk_now("enter_stable", mk(1'b0, 8'd0, ST_STABLE));
    tick_to(40 + SYNC + ST);
    chk_now("stable_last", mk(1'b0, 8'd0, ST_STABLE));
    tick();
    chk_now("core_release", mk(1'b0, 8'd0, ST_RUN));

    // asynchronous reset mid-RUN, away from any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk_now("reset_mid_run", mk(1'b0, 8'd0, ST_PLL_RST));
    repeat (2) tick();
    do_release();
    check_rst_pulse("rst_pulse_restart");
    tick();
    chk_now("restart_stable", mk(1'b0, 8'd0, ST_STABLE));

    // one-cycle lock glitch in the middle of STABLE
    tick_to(40);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick_to(42);
    chk_now("glitch_pre", mk(1'b0, 8'd0, ST_STABLE));
    tick();
    chk_now("glitch_wait_lock", mk(1'b0, 8'd0, ST_WAIT_LOCK));
    tick();
    chk_now("glitch_restable", mk(1'b0, 8'd0, ST_STABLE));
    tick_to(44 + ST - 1);
    chk_now("glitch_count_restart", mk(1'b0, 8'd0, ST_STABLE));
    tick();
    chk_now("glitch_run", mk(1'b0, 8'd0, ST_RUN));

    // 300 lock losses in RUN; relock_count saturates
    for (int i = 0; i < 300; i++) lose_lock(1'b0);
    chk1("relock_saturated", relock_count == 8'hFF, 1'b1);

    // clear alone, then clear racing a relock increment
    clear_err = 1'b1;
    tick();
    clear_err  = 1'b0;
    exp_relock = 8'd0;
    chk_now("clear_relock", mk(1'b0, 8'd0, ST_RUN));
    lose_lock(1'b1);

    // PLL never locks: timeout and a second pll_rst pulse
    pll_locked = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    exp_relock = 8'd0;
    chk_now("reset_before_timeout", mk(1'b0, 8'd0, ST_PLL_RST));
    repeat (2) tick();
    do_release();
    tick_to(RST + TO - 1);
    chk_now("timeout_pre", mk(1'b0, 8'd0, ST_WAIT_LOCK));
    tick();
    chk_now("timeout_hit", mk(1'b1, 8'd0, ST_PLL_RST));
    tick_to(2 * RST + TO - 1);
    chk_now("repulse_last", mk(1'b1, 8'd0, ST_PLL_RST));
    tick();
    chk_now("repulse_end", mk(1'b1, 8'd0, ST_WAIT_LOCK));

    // clear, then clear on the same cycle as the next timeout, then clear alone
    tick_to(2 * RST + TO + 8);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk_now("clear_in_wait", mk(1'b0, 8'd0, ST_WAIT_LOCK));
    tick_to(2 * RST + 2 * TO - 1);
    chk_now("timeout2_pre", mk(1'b0, 8'd0, ST_WAIT_LOCK));
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk_now("timeout_clear_race", mk(1'b1, 8'd0, ST_PLL_RST));
    tick_to(2 * RST + 2 * TO + 8);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk_now("clear_alone", mk(1'b0, 8'd0, ST_PLL_RST));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
